// File: rtl/sequenciador_valvula_pkg.sv
// Shared types and default timing for the valve dose sequencer.
// The enum values double as the debug state encoding.
package sequenciador_valvula_pkg;

    typedef enum logic [2:0] {
        ST_OCIOSO  = 3'd0,
        ST_DISPARA = 3'd1,
        ST_AGUARDA = 3'd2,
        ST_PAUSA   = 3'd3,
        ST_CONCLUI = 3'd4,
        ST_ERRO    = 3'd5
    } estado_t;

    // The defaults assume a 50 MHz clock_sys.
    localparam longint unsigned TIMEOUT_PADRAO = 64'd3100000000;
    localparam longint unsigned PAUSA_PADRAO   = 64'd50000000;

endpackage

// File: rtl/sequenciador_valvula_contador.sv
// Up-counter with a synchronous clear. fim is high while the count sits on its
// last value (MODULO-1), so the caller decides what happens next.
module contador_m #(
    parameter int              W      = 8,
    parameter longint unsigned MODULO = 256
) (
    input  logic clock,
    input  logic zera_s,
    input  logic conta,
    output logic fim
);

    localparam logic [W-1:0] ULTIMO = W'(MODULO - 1);

    logic [W-1:0] valor;

    always_ff @(posedge clock) begin
        if (zera_s) begin
            valor <= '0;
        end else if (conta) begin
            valor <= valor + W'(1);
        end
    end

    assign fim = (valor == ULTIMO);

endmodule

// File: rtl/sequenciador_valvula.sv
// Valve handshake initiator: runs n_doses dose cycles (start pulse, wait for
// fim_valvula, fixed pause), with a per-dose timeout and a level cancel request.
//
// state      | meaning
// OCIOSO     | idle, waiting for iniciar
// DISPARA    | one-cycle start pulse to the valve timer
// AGUARDA    | waiting for the dose-done edge, timeout running
// PAUSA      | fixed gap before the next dose
// CONCLUI    | one-cycle pronto, run finished normally
// ERRO       | a dose timed out; erro held until the next accepted iniciar
module sequenciador_valvula
    import sequenciador_valvula_pkg::*;
#(
    parameter longint unsigned TIMEOUT   = TIMEOUT_PADRAO,
    parameter int              W_TIMEOUT = 32,
    parameter longint unsigned PAUSA     = PAUSA_PADRAO,
    parameter int              W_PAUSA   = 26,
    parameter int              W_DOSES   = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               iniciar,
    input  logic               cancelar,
    input  logic [W_DOSES-1:0] n_doses,
    input  logic               fim_valvula,
    output logic               liga_valvula,
    output logic               ocupado,
    output logic               pronto,
    output logic               erro,
    output logic [W_DOSES-1:0] dose_atual,
    output logic [2:0]         db_estado
);

    estado_t            estado, prox;
    logic               fim_r, fim_ev;
    logic               fim_timeout, fim_pausa;
    logic [W_DOSES-1:0] alvo;
    logic               cancel_q;
    logic               aceita, conta_dose, marca_cancel;
    logic [W_DOSES:0]   dose_prox;
    logic               atinge;

    assign fim_ev    = fim_valvula & ~fim_r;
    assign dose_prox = {1'b0, dose_atual} + {{W_DOSES{1'b0}}, 1'b1};
    assign atinge    = (dose_prox == {1'b0, alvo});

    contador_m #(.W(W_TIMEOUT), .MODULO(TIMEOUT)) u_timeout (
        .clock  (clock),
        .zera_s (reset | (estado == ST_DISPARA)),
        .conta  (estado == ST_AGUARDA),
        .fim    (fim_timeout)
    );

    contador_m #(.W(W_PAUSA), .MODULO(PAUSA)) u_pausa (
        .clock  (clock),
        .zera_s (reset | ((prox == ST_PAUSA) && (estado != ST_PAUSA))),
        .conta  (estado == ST_PAUSA),
        .fim    (fim_pausa)
    );

    always_comb begin
        prox         = estado;
        aceita       = 1'b0;
        conta_dose   = 1'b0;
        marca_cancel = 1'b0;
        case (estado)
            ST_OCIOSO, ST_ERRO: begin
                if (iniciar) begin
                    aceita = 1'b1;
                    prox   = (n_doses == '0) ? ST_CONCLUI : ST_DISPARA;
                end
            end
            // A started dose cannot be aborted: cancel is remembered until fim.
            ST_DISPARA: begin
                prox         = ST_AGUARDA;
                marca_cancel = cancelar;
            end
            ST_AGUARDA: begin
                marca_cancel = cancelar;
                if (fim_ev) begin
                    conta_dose = 1'b1;
                    if (cancel_q | cancelar) prox = ST_OCIOSO;
                    else if (atinge)         prox = ST_CONCLUI;
                    else                     prox = ST_PAUSA;
                end else if (fim_timeout) begin
                    prox = ST_ERRO;
                end
            end
            ST_PAUSA: begin
                if (cancelar)       prox = ST_OCIOSO;
                else if (fim_pausa) prox = ST_DISPARA;
            end
            ST_CONCLUI: prox = ST_OCIOSO;
            default:    prox = ST_OCIOSO;
        endcase
    end

    // Outputs are registered from the next state so they line up with estado.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado       <= ST_OCIOSO;
            fim_r        <= 1'b0;
            liga_valvula <= 1'b0;
            pronto       <= 1'b0;
            ocupado      <= 1'b0;
            erro         <= 1'b0;
            alvo         <= '0;
            dose_atual   <= '0;
            cancel_q     <= 1'b0;
        end else begin
            estado       <= prox;
            fim_r        <= fim_valvula;
            liga_valvula <= (prox == ST_DISPARA);
            pronto       <= (prox == ST_CONCLUI);
            ocupado      <= !(prox inside {ST_OCIOSO, ST_ERRO});
            erro         <= (prox == ST_ERRO);
            if (aceita) begin
                alvo       <= n_doses;
                dose_atual <= '0;
            end else if (conta_dose && (dose_atual != alvo)) begin
                dose_atual <= dose_prox[W_DOSES-1:0];
            end
            if (aceita || (prox == ST_OCIOSO)) begin
                cancel_q <= 1'b0;
            end else if (marca_cancel) begin
                cancel_q <= 1'b1;
            end
        end
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_sequenciador_valvula.sv
// Scoreboard bench for the valve sequencer: each run's outcome is predicted from
// the dose rules and checked by a monitor when ocupado drops.
module tb_sequenciador_valvula;

    localparam int TIMEOUT = 20;
    localparam int PAUSA   = 5;

    logic       clock = 1'b0;
    logic       reset, iniciar, cancelar, fim_valvula;
    logic [2:0] n_doses;
    logic       liga_valvula, ocupado, pronto, erro;
    logic [2:0] dose_atual, db_estado;

    typedef struct {
        int liga;
        int dose;
        int pronto;
        int erro;
    } esperado_t;

    esperado_t fila[$];

    int checks = 0;
    int errors = 0;
    int ciclo = 0;
    int atraso = 0;
    int hold_fixo = 0;

    int        m_liga_run = 0;
    int        m_pronto_run = 0;
    int        m_ult = 0;
    bit        m_ocup_ant = 0;
    bit        m_liga_ant = 0;
    bit        m_erro_ant = 0;
    esperado_t m_e;

    sequenciador_valvula #(
        .TIMEOUT   (TIMEOUT),
        .W_TIMEOUT (32),
        .PAUSA     (PAUSA),
        .W_PAUSA   (26),
        .W_DOSES   (3)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .cancelar     (cancelar),
        .n_doses      (n_doses),
        .fim_valvula  (fim_valvula),
        .liga_valvula (liga_valvula),
        .ocupado      (ocupado),
        .pronto       (pronto),
        .erro         (erro),
        .dose_atual   (dose_atual),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        ciclo++;
    end

    task automatic verifica(input string nome, input int atual, input int req);
        checks++;
        if (atual != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nome, atual, req, ciclo);
        end
    endtask

    // Outcome of a whole run from the dose rules: a dose finishes only if the
    // valve answers within TIMEOUT cycles of the pulse; the first late dose ends in erro.
    function automatic esperado_t modelo(input int n, input int d, input int cmode, input int cj);
        esperado_t e;
        if (n == 0)                       e = '{0, 0, 1, 0};
        else if (d == 0 || d > TIMEOUT)   e = '{1, 0, 0, 1};
        else if (cmode != 0)              e = '{cj, cj, 0, 0};
        else                              e = '{n, n, 1, 0};
        return e;
    endfunction

    // Valve timer stand-in: fim rises atraso cycles after each pulse, held 1..4 cycles.
    initial begin
        int h;
        fim_valvula = 1'b0;
        forever begin
            @(negedge clock);
            if (liga_valvula && atraso != 0) begin
                h = (hold_fixo != 0) ? hold_fixo : int'($urandom_range(1, 4));
                repeat (atraso) @(negedge clock);
                fim_valvula = 1'b1;
                repeat (h) @(negedge clock);
                fim_valvula = 1'b0;
            end
        end
    end

    // Monitor: per-pulse checks, then one scoreboard pop each time ocupado falls.
    initial forever begin
        @(negedge clock);
        if (liga_valvula) begin
            verifica("liga_one_cycle", int'(m_liga_ant), 0);
            if (m_liga_run > 0) begin
                checks++;
                if (ciclo - m_ult <= PAUSA) begin
                    errors++;
                    $display("FAIL liga_gap: got %0d cycles, expected more than %0d", ciclo - m_ult, PAUSA);
                end
            end
            m_liga_run++;
            m_ult = ciclo;
        end
        if (pronto) m_pronto_run++;
        if (erro && !m_erro_ant) verifica("erro_latency", ciclo - m_ult, TIMEOUT + 1);
        if (m_ocup_ant && !ocupado) begin
            if (fila.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: got end of run, expected none");
            end else begin
                m_e = fila.pop_front();
                verifica("run_liga_count", m_liga_run, m_e.liga);
                verifica("run_pronto_count", m_pronto_run, m_e.pronto);
                verifica("run_erro", int'(erro), m_e.erro);
                verifica("run_dose_atual", int'(dose_atual), m_e.dose);
            end
            m_liga_run = 0;
            m_pronto_run = 0;
        end
        m_ocup_ant = ocupado;
        m_liga_ant = liga_valvula;
        m_erro_ant = erro;
    end

    // Leaves the caller on the negedge where the j-th pulse of this run is high.
    task automatic espera_liga(input int j);
        int k;
        int t;
        k = liga_valvula ? 1 : 0;
        t = 0;
        while (k < j && t < 1000) begin
            @(negedge clock);
            t++;
            if (liga_valvula) k++;
        end
        if (k < j) begin
            checks++;
            errors++;
            $display("FAIL wait_liga: got %0d pulses, expected %0d", k, j);
        end
    endtask

    task automatic inicia(input int n);
        @(negedge clock);
        n_doses = 3'(n);
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        n_doses = 3'($urandom_range(0, 7));
        verifica("ocupado_after_start", int'(ocupado), 1);
        verifica("erro_cleared_on_start", int'(erro), 0);
    endtask

    task automatic executar(input int n, input int d, input int cmode, input int cj,
                            input bit spam, input bit em_disp);
        int t;
        atraso = d;
        fila.push_back(modelo(n, d, cmode, cj));
        inicia(n);
        if (cmode == 0 && spam && n > 0) begin
            espera_liga(1);
            repeat (3) @(negedge clock);
            iniciar = 1'b1;
            n_doses = 3'($urandom_range(0, 7));
            @(negedge clock);
            iniciar = 1'b0;
        end else if (cmode == 1) begin
            espera_liga(cj);
            if (!em_disp) @(negedge clock);
            cancelar = 1'b1;
            @(negedge clock);
            cancelar = 1'b0;
        end else if (cmode == 2) begin
            espera_liga(cj);
            repeat (d + 2) @(negedge clock);
            cancelar = 1'b1;
            @(negedge clock);
            cancelar = 1'b0;
            verifica("state_after_pause_cancel", int'(db_estado), 0);
        end
        t = 0;
        while (ocupado && t < 3000) begin
            @(negedge clock);
            t++;
        end
        if (ocupado) begin
            checks++;
            errors++;
            $display("FAIL run_end_timeout: got ocupado=1, expected 0");
            reset = 1'b1;
            @(negedge clock);
            reset = 1'b0;
        end
        repeat (30) @(negedge clock);
    endtask

    initial begin
        int n, d, cmode, cj, sel;
        bit spam, em_disp;

        reset = 1'b1;
        iniciar = 1'b0;
        cancelar = 1'b0;
        n_doses = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        verifica("reset_liga", int'(liga_valvula), 0);
        verifica("reset_ocupado", int'(ocupado), 0);
        verifica("reset_pronto", int'(pronto), 0);
        verifica("reset_erro", int'(erro), 0);
        verifica("reset_dose", int'(dose_atual), 0);
        verifica("reset_estado", int'(db_estado), 0);

        hold_fixo = 4;
        executar(2, 10, 0, 0, 0, 0);
        hold_fixo = 0;
        executar(0, 10, 0, 0, 0, 0);
        executar(3, 0, 0, 0, 0, 0);
        executar(1, 10, 0, 0, 0, 0);
        executar(2, 20, 0, 0, 0, 0);
        executar(3, 21, 0, 0, 0, 0);
        executar(3, 10, 2, 1, 0, 0);
        executar(3, 10, 1, 2, 0, 0);
        executar(3, 12, 1, 1, 0, 1);
        executar(7, 10, 0, 0, 1, 0);

        // Reset in the middle of a dose wait.
        atraso = 10;
        fila.push_back('{1, 0, 0, 0});
        inicia(3);
        espera_liga(1);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        verifica("midreset_liga", int'(liga_valvula), 0);
        verifica("midreset_ocupado", int'(ocupado), 0);
        verifica("midreset_dose", int'(dose_atual), 0);
        verifica("midreset_estado", int'(db_estado), 0);
        repeat (40) @(negedge clock);

        for (int r = 0; r < 25; r++) begin
            n = int'($urandom_range(0, 7));
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      d = 0;
            else if (sel == 1) d = 20;
            else if (sel == 2) d = 21;
            else               d = int'($urandom_range(2, 19));
            cmode = int'($urandom_range(0, 2));
            cj = 0;
            if (d == 0 || d > TIMEOUT || n == 0) cmode = 0;
            if (cmode == 1) cj = int'($urandom_range(1, n));
            if (cmode == 2) begin
                if (n < 2) cmode = 0;
                else cj = int'($urandom_range(1, n - 1));
            end
            spam = 1'($urandom_range(0, 1));
            em_disp = 1'($urandom_range(0, 1));
            executar(n, d, cmode, cj, spam, em_disp);
        end

        verifica("scoreboard_drained", fila.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
